adder_arbiter: RTL and testbench
================================

# adder_arbiter

Shares one ripple-carry WIDTH-bit add/subtract datapath between N_REQ requesters through round-robin arbitration with valid/ready handshakes on both sides. Each accepted request produces one registered result carrying the sum, the ALU flags (carry, overflow, zero, negative) and the requester ID. The block sits between the ALU's operation sources (ALU ops, address/PC incrementers, compare logic) and the single adder chain built from per-bit Adder cells.

## Interface
- WIDTH, 16, operand/result width in bits
- N_REQ, 4, number of requesters (2..8); IDW = clog2(N_REQ), minimum 1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; one-hot or zero
- req_a  in  N_REQ*WIDTH  operand A; requester i in bits [i*WIDTH +: WIDTH]
- req_b  in  N_REQ*WIDTH  operand B; same packing
- req_sub  in  N_REQ  1 = compute A-B, 0 = compute A+B
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  downstream consumes result
- rsp_id  out  IDW  index of the requester that produced the result
- rsp_sum  out  WIDTH  result
- rsp_carry  out  1  carry out of the MSB (for subtract, 1 = no borrow)
- rsp_overflow  out  1  signed overflow
- rsp_zero  out  1  rsp_sum == 0
- rsp_neg  out  1  rsp_sum[WIDTH-1]

## Operation
- Datapath:
  - Computes sum = A + (sub ? ~B : B) + sub through a WIDTH-cell chain of per-bit full adders, with carry-in = sub.
  - carry = carry out of bit WIDTH-1.
  - overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - All arithmetic is modulo 2^WIDTH and is identical for signed and unsigned operands.
- Output register: a single-entry register with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = !rsp_valid || rsp_ready.
- Arbitration:
  - Pointer ptr (IDW bits) marks the highest-priority requester.
  - Search order is ptr, ptr+1, … wrapping modulo N_REQ.
  - The first i with req_valid[i]=1 is the grant.
  - req_ready[grant] = can_accept; all other req_ready bits are 0.
  - If no requester is valid, all req_ready bits are 0.
- Handshake:
  - A transfer occurs on requester i when req_valid[i] && req_ready[i] at a rising edge.
  - On transfer, the result register loads sum/flags/id = i and ptr ← (i+1) mod N_REQ.
  - Without a transfer, ptr holds.
- Transitions:
  - EMPTY, no transfer → EMPTY.
  - EMPTY, transfer → FULL.
  - FULL, !rsp_ready → FULL; all rsp_* outputs held bit-stable.
  - FULL, rsp_ready, no transfer → EMPTY.
  - FULL, rsp_ready, transfer → FULL with new contents (back-to-back).
- req_ready depends combinationally on req_valid, ptr, rsp_valid and rsp_ready. There is no combinational path from req_a/req_b/req_sub to any output.
- Requesters must hold request fields stable while valid and not accepted. Dropping valid before acceptance is permitted and simply removes the requester from arbitration.
- Reset (asynchronous, any time, including mid-transfer or while FULL):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, all flags 0, ptr=0.
  - A pending result is discarded.
  - req_ready is all 0 while rst is high.

## Timing
- Latency: result visible exactly 1 cycle after the accepting edge.
- Throughput: one result per cycle while rsp_ready stays high.
- Fairness: with all N_REQ requesters continuously valid and no backpressure, grants cycle 0,1,…,N_REQ-1,0… A requester waits at most N_REQ-1 transfers.
- Backpressure: when FULL and rsp_ready=0, no request is accepted. Acceptance resumes in the same cycle rsp_ready rises.
- First edge after rst deasserts may accept a request. Priority then starts at requester 0.
- Ripple chain of WIDTH cells plus the arbitration mux is the single-cycle critical path.

## Test plan
- Reset mid-operation: FULL with rsp_sum=0x1234, assert rst between edges. Required: rsp_valid and all rsp_* fields go to 0 immediately; after release, simultaneous req0 and req2 → req0 granted first.
- Signed overflow: req0 A=0x7FFF, B=0x0001, sub=0. Required: next cycle rsp_sum=0x8000, carry=0, overflow=1, neg=1, zero=0, id=0.
- Subtract: req1 A=0x0005, B=0x0005, sub=1. Required: sum=0x0000, carry=1, zero=1, overflow=0. Then A=0x0000, B=0x0001, sub=1. Required: sum=0xFFFF, carry=0, neg=1.
- Unsigned wrap: req3 A=0xFFFF, B=0x0001, sub=0. Required: sum=0x0000, carry=1, overflow=0, zero=1, id=3.
- Round-robin: all four requesters valid continuously, rsp_ready=1 for 8 cycles. Required: rsp_id sequence 0,1,2,3,0,1,2,3 with rsp_valid high every cycle.
- Backpressure: FULL, rsp_ready=0 for 3 cycles with req1 valid. Required: req_ready=0000 and rsp_* stable; the cycle rsp_ready=1 → req_ready=0010 and the next result has id=1.

Source files
------------

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one ripple-carry add/sub datapath
// Results are registered in a single-entry EMPTY/FULL output stage with valid/ready handshakes.
module adder_arbiter #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_sum,
    output logic                   rsp_carry,
    output logic                   rsp_overflow,
    output logic                   rsp_zero,
    output logic                   rsp_neg
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_next;
    logic [IDW-1:0]   ptr, ptr_next;
    logic [IDW-1:0]   grant;
    logic             found;
    logic             can_accept;
    logic             fire;
    logic [N_REQ-1:0] rot;
    logic [IDW:0]     gsum;
    logic [IDW:0]     gnext;

    assign rsp_valid  = (state == FULL);
    assign can_accept = !rsp_valid || rsp_ready;

    // Rotate requests so bit 0 is the current highest-priority requester.
    always_comb begin
        rot   = N_REQ'({req_valid, req_valid} >> ptr);
        found = 1'b0;
        grant = '0;
        gsum  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                gsum  = {1'b0, ptr} + (IDW+1)'(k);
                if (gsum >= (IDW+1)'(N_REQ))
                    grant = IDW'(gsum - (IDW+1)'(N_REQ));
                else
                    grant = IDW'(gsum);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && can_accept && !rst)
            req_ready[grant] = 1'b1;
    end

    assign fire = |(req_valid & req_ready);

    always_comb begin
        gnext    = {1'b0, grant} + (IDW+1)'(1);
        ptr_next = ptr;
        if (fire)
            ptr_next = (gnext == (IDW+1)'(N_REQ)) ? '0 : IDW'(gnext);
    end

    // Shared datapath: operands muxed from the granted requester into one carry chain.
    logic [WIDTH-1:0] op_a, op_b, b_eff, sum;
    logic             op_sub;
    logic [WIDTH:0]   c;

    assign op_a   = req_a[grant*WIDTH +: WIDTH];
    assign op_b   = req_b[grant*WIDTH +: WIDTH];
    assign op_sub = req_sub[grant];
    assign b_eff  = op_b ^ {WIDTH{op_sub}};
    assign c[0]   = op_sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum[i]   = op_a[i] ^ b_eff[i] ^ c[i];
        assign c[i+1]   = (op_a[i] & b_eff[i]) | (c[i] & (op_a[i] ^ b_eff[i]));
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (fire) state_next = FULL;
            FULL:  if (rsp_ready && !fire) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ptr   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id       <= '0;
            rsp_sum      <= '0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_neg      <= 1'b0;
        end else if (fire) begin
            rsp_id       <= grant;
            rsp_sum      <= sum;
            rsp_carry    <= c[WIDTH];
            rsp_overflow <= c[WIDTH-1] ^ c[WIDTH];
            rsp_zero     <= (sum == '0);
            rsp_neg      <= sum[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

    localparam int WIDTH = 16;
    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_sub;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_carry;
    logic                   rsp_overflow;
    logic                   rsp_zero;
    logic                   rsp_neg;

    int passed;
    int total;

    adder_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sub      (req_sub),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_sum      (rsp_sum),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .rsp_neg      (rsp_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp)
            passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic sub);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_sub[i]              = sub;
    endtask

    // Packs {valid, id, sum, carry, ovf, zero, neg} for one-shot result checks.
    task automatic check_rsp(input string tag, input logic [1:0] id, input logic [15:0] sum,
                             input logic cy, input logic ov, input logic z, input logic n);
        check(tag, {11'd0, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow, rsp_zero, rsp_neg},
                   {11'd0, 1'b1, id, sum, cy, ov, z, n});
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b0;

        tick();
        req_valid = 4'b0101;
        tick();
        check("reset_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_sum", {16'd0, rsp_sum}, 32'd0);
        check("reset_ready", {28'd0, req_ready}, 32'd0);

        set_op(0, 16'h7FFF, 16'h0001, 1'b0);
        set_op(2, 16'h0010, 16'h0003, 1'b1);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("first_grant_req0", {28'd0, req_ready}, 32'h1);

        tick();
        check_rsp("signed_overflow", 2'd0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        req_valid = 4'b0100;
        #1;
        check("grant_req2", {28'd0, req_ready}, 32'h4);
        tick();
        check_rsp("sub_no_borrow", 2'd2, 16'h000D, 1'b1, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0000;
        tick();
        check("drain_empty", {31'd0, rsp_valid}, 32'd0);

        set_op(1, 16'h0005, 16'h0005, 1'b1);
        req_valid = 4'b0010;
        tick();
        check_rsp("sub_equal", 2'd1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        set_op(1, 16'h0000, 16'h0001, 1'b1);
        tick();
        check_rsp("sub_borrow", 2'd1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        set_op(3, 16'hFFFF, 16'h0001, 1'b0);
        req_valid = 4'b1000;
        tick();
        check_rsp("unsigned_wrap", 2'd3, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        req_valid = 4'b0000;
        tick();

        for (int i = 0; i < N_REQ; i++)
            set_op(i, 16'(i * 16'h0100), 16'(i), 1'b0);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("rr_%0d", k), {13'd0, rsp_valid, rsp_id, rsp_sum},
                  {13'd0, 1'b1, 2'(k % 4), 16'((k % 4) * 16'h0101)});
        end

        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 16'h1111, 16'h2222, 1'b0);
        #1;
        check("bp_ready_now", {28'd0, req_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold_%0d", k), {8'd0, req_ready, 1'b0, rsp_valid, rsp_id, rsp_sum},
                  {8'd0, 4'b0000, 1'b0, 1'b1, 2'd3, 16'h0303});
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'd0, req_ready}, 32'h2);
        tick();
        check_rsp("bp_result", 2'd1, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0);

        set_op(0, 16'h1000, 16'h0234, 1'b0);
        req_valid = 4'b0001;
        tick();
        check_rsp("pre_reset_full", 2'd0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        req_valid = 4'b0101;
        #2;
        rst = 1'b1;
        #1;
        check("midreset_rsp", {13'd0, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_overflow, rsp_zero},
              32'd0);
        check("midreset_neg", {31'd0, rsp_neg}, 32'd0);
        check("midreset_ready", {28'd0, req_ready}, 32'd0);
        tick();
        set_op(0, 16'h0001, 16'h0002, 1'b0);
        set_op(2, 16'h0020, 16'h0001, 1'b1);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("post_reset_ready", {28'd0, req_ready}, 32'h1);
        tick();
        check_rsp("post_reset_req0", 2'd0, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        req_valid = 4'b0100;
        tick();
        check_rsp("post_reset_req2", 2'd2, 16'h001F, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
